// File: rtl/seizure_alarm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seizure_alarm: K-of-N vote over per-window seizure decisions with hysteresis |
// | and a refractory hold period.               Rev 1.0 - initial release        |
// +----------------------------------------------------------------------------+
module seizure_alarm #(
  parameter int HIST_LEN     = 8,
  parameter int VOTE_K       = 6,
  parameter int CLEAR_K      = 2,
  parameter int HOLD_WINDOWS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seizure_in,
  input  logic       seizure_valid,
  input  logic       clear,
  output logic       alarm,
  output logic       alarm_onset,
  output logic       in_hold,
  output logic [3:0] vote_count,
  output logic [7:0] event_count
);

  localparam int                HOLD_W    = $clog2(HOLD_WINDOWS + 1);
  localparam logic [3:0]        VOTE_TH   = 4'(VOTE_K);
  localparam logic [3:0]        CLEAR_TH  = 4'(CLEAR_K);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_WINDOWS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(1);
  localparam logic [7:0]        EVT_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALARM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [HIST_LEN-1:0] hist_q, hist_d;
  logic [HIST_LEN-1:0] hist_shift;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                alarm_q, alarm_d;
  logic                onset_q, onset_d;
  logic                in_hold_q, in_hold_d;
  logic [3:0]          vote_q, vote_d;
  logic [7:0]          event_q, event_d;
  logic [3:0]          cnt_next;

  function automatic logic [3:0] popcount(input logic [HIST_LEN-1:0] v);
    logic [3:0] acc;
    acc = 4'd0;
    for (int i = 0; i < HIST_LEN; i++) begin
      acc = acc + 4'(v[i]);
    end
    return acc;
  endfunction

  always_comb begin
    hist_shift = {hist_q[HIST_LEN-2:0], seizure_in};
    cnt_next   = popcount(hist_shift);

    hist_d     = hist_q;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    event_d    = event_q;
    onset_d    = 1'b0;

    // clear outranks a coincident strobe, so the sample is simply dropped
    if (clear) begin
      hist_d     = '0;
      state_d    = ST_IDLE;
      hold_cnt_d = '0;
    end else if (seizure_valid) begin
      hist_d = hist_shift;
      case (state_q)
        ST_IDLE: begin
          if (cnt_next >= VOTE_TH) begin
            state_d = ST_ALARM;
            onset_d = 1'b1;
            if (event_q != EVT_MAX) begin
              event_d = event_q + 8'd1;
            end
          end
        end
        ST_ALARM: begin
          if (cnt_next <= CLEAR_TH) begin
            state_d    = ST_HOLD;
            hold_cnt_d = HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          // votes are ignored here; only the window countdown matters
          if (hold_cnt_q <= HOLD_LAST) begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q - HOLD_LAST;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end

    alarm_d   = (state_d == ST_ALARM);
    in_hold_d = (state_d == ST_HOLD);
    vote_d    = popcount(hist_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hist_q     <= '0;
      hold_cnt_q <= '0;
      alarm_q    <= 1'b0;
      onset_q    <= 1'b0;
      in_hold_q  <= 1'b0;
      vote_q     <= 4'd0;
      event_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      hold_cnt_q <= hold_cnt_d;
      alarm_q    <= alarm_d;
      onset_q    <= onset_d;
      in_hold_q  <= in_hold_d;
      vote_q     <= vote_d;
      event_q    <= event_d;
    end
  end

  assign alarm       = alarm_q;
  assign alarm_onset = onset_q;
  assign in_hold     = in_hold_q;
  assign vote_count  = vote_q;
  assign event_count = event_q;

endmodule
`default_nettype wire
